data_mem_arbiter: RTL and testbench

- Shares the single-port 16-bit data memory (256 words, byte address bits [8:1], synchronous write, combinational read) between two requesters.
- Requester 0 is the core load/store stage; requester 1 is the image loader/DMA engine.
- Grants one access per cycle using round-robin with a bounded burst.
- Drives the memory's address, write-data, write-enable and read-enable, and returns registered read data per requester.

---
 rtl/data_mem_arbiter_if.sv | 27 ++
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The slave side is the arbiter; the master side is the requesters plus the memory.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata, r0_rdata;
   logic              r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata, r1_rdata;
   logic [ADDR_W-1:0] mem_access_addr;
   logic [DATA_W-1:0] mem_write_data, mem_read_data;
   logic              mem_write_en, mem_read;

   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, mem_read_data,
      output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
             mem_access_addr, mem_write_data, mem_write_en, mem_read
   );
   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, mem_read_data,
      input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
             mem_access_addr, mem_write_data, mem_write_en, mem_read
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port data memory between
// the core load/store stage (r0) and the image loader / DMA engine (r1).

// Per-requester read return: captures memory data on a granted read.
module data_mem_arbiter_rport #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fire,
   input  logic [DATA_W-1:0] din,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= fire;
         if (fire) rdata <= din;
      end
   end
endmodule

module data_mem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   data_mem_arbiter_if.slave     bus
);
   localparam logic [3:0] MB = 4'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t                       state, state_n;
   logic [3:0]                   cnt, cnt_n;
   logic                         rr, rr_n;
   logic [1:0]                   req, we, gnt, rd_fire, rvalid;
   logic [1:0][ADDR_W-1:0]       addr;
   logic [1:0][DATA_W-1:0]       wdata, rdata;
   logic                         gnt_any, gnt_sel, grant_ok, owner;

   assign req   = {bus.r1_req, bus.r0_req};
   assign we    = {bus.r1_we, bus.r0_we};
   assign addr  = {bus.r1_addr, bus.r0_addr};
   assign wdata = {bus.r1_wdata, bus.r0_wdata};

   always_comb begin
      gnt_any = 1'b0;
      gnt_sel = rr;
      owner   = (state == OWN1);
      if (state == IDLE) begin
         gnt_any = |req;
         gnt_sel = (&req) ? rr : req[1];
      end else if (req[owner] && (!req[~owner] || cnt < MB)) begin
         gnt_any = 1'b1;
         gnt_sel = owner;
      end else if (req[~owner]) begin
         gnt_any = 1'b1;
         gnt_sel = ~owner;
      end
   end

   // Gate with rst_n so nothing reaches the memory while reset is asserted,
   // including partway through a cycle.
   assign grant_ok = gnt_any & rst_n;
   assign gnt      = grant_ok ? (2'b01 << gnt_sel) : 2'b00;
   assign rd_fire  = gnt & ~we;

   assign bus.r0_gnt          = gnt[0];
   assign bus.r1_gnt          = gnt[1];
   assign bus.mem_access_addr = grant_ok ? addr[gnt_sel]  : '0;
   assign bus.mem_write_data  = grant_ok ? wdata[gnt_sel] : '0;
   assign bus.mem_write_en    = grant_ok &  we[gnt_sel];
   assign bus.mem_read        = grant_ok & ~we[gnt_sel];

   always_comb begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      rr_n    = rr;
      if (grant_ok) begin
         state_n = gnt_sel ? OWN1 : OWN0;
         rr_n    = ~gnt_sel;
         if (state == IDLE || owner != gnt_sel) cnt_n = 4'd1;
         else                                  cnt_n = (cnt >= MB) ? MB : cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         rr    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         rr    <= rr_n;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_rport
      data_mem_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
         .clk    (clk),
         .rst_n  (rst_n),
         .fire   (rd_fire[i]),
         .din    (bus.mem_read_data),
         .rvalid (rvalid[i]),
         .rdata  (rdata[i])
      );
   end

   assign bus.r0_rvalid = rvalid[0];
   assign bus.r0_rdata  = rdata[0];
   assign bus.r1_rvalid = rvalid[1];
   assign bus.r1_rdata  = rdata[1];
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand sequences and random
// traffic checked against a behavioural arbitration + memory model.
module tb_data_mem_arbiter;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory behind the arbiter: combinational read, synchronous write.
   logic [15:0] tb_mem [256];
   assign bus.mem_read_data = tb_mem[bus.mem_access_addr[8:1]];
   always @(posedge clk) if (bus.mem_write_en) tb_mem[bus.mem_access_addr[8:1]] <= bus.mem_write_data;

   // Reference model state.
   logic [15:0] ref_mem [256];
   int          m_owner, m_run;
   int          m_pref;
   logic        e_rvalid [2];
   logic [15:0] e_rdata [2];

   int n_chk = 0, n_fail = 0;

   typedef struct {
      logic q0, w0; logic [15:0] a0, d0;
      logic q1, w1; logic [15:0] a1, d1;
      int   exp_g;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_run = 0; m_pref = 0;
      for (int k = 0; k < 2; k++) begin e_rvalid[k] = 1'b0; e_rdata[k] = 16'h0; end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input logic q0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic q1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                       output int g);
      logic q[2], w[2];
      logic [15:0] a[2], d[2];
      q[0] = q0; w[0] = w0; a[0] = a0; d[0] = d0;
      q[1] = q1; w[1] = w1; a[1] = a1; d[1] = d1;
      @(negedge clk);
      bus.r0_req = q0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_wdata = d0;
      bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1;
      #1;
      // Who should be granted: a lone requester always wins; under contention the
      // current owner keeps the memory until it has had MB grants in a row.
      if (!q[0] && !q[1])      g = -1;
      else if (q[0] != q[1])   g = q[0] ? 0 : 1;
      else if (m_owner < 0)    g = m_pref;
      else if (m_run < MB)     g = m_owner;
      else                     g = 1 - m_owner;

      chk("r0_gnt", bus.r0_gnt, g == 0);
      chk("r1_gnt", bus.r1_gnt, g == 1);
      chk("r0_rvalid", bus.r0_rvalid, e_rvalid[0]);
      chk("r1_rvalid", bus.r1_rvalid, e_rvalid[1]);
      chk("r0_rdata", bus.r0_rdata, e_rdata[0]);
      chk("r1_rdata", bus.r1_rdata, e_rdata[1]);
      if (g < 0) begin
         chk("idle_mem_outs", {bus.mem_write_en, bus.mem_read, bus.mem_access_addr, bus.mem_write_data}, 0);
      end else begin
         chk("mem_write_en", bus.mem_write_en, w[g]);
         chk("mem_read", bus.mem_read, !w[g]);
         chk("mem_access_addr", bus.mem_access_addr, a[g]);
         if (w[g]) chk("mem_write_data", bus.mem_write_data, d[g]);
      end

      e_rvalid[0] = 1'b0; e_rvalid[1] = 1'b0;
      if (g < 0) begin
         m_owner = -1; m_run = 0;
      end else begin
         if (w[g]) ref_mem[a[g][8:1]] = d[g];
         else begin e_rvalid[g] = 1'b1; e_rdata[g] = ref_mem[a[g][8:1]]; end
         m_run   = (g == m_owner) ? ((m_run + 1 > MB) ? MB : m_run + 1) : 1;
         m_owner = g;
         m_pref  = 1 - g;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int g;
      logic pv[2], pw[2];
      logic [15:0] pa[2], pd[2];
      for (int k = 0; k < 256; k++) begin tb_mem[k] = 16'h0; ref_mem[k] = 16'h0; end
      model_reset();
      bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 16'h0010; bus.r0_wdata = 16'h5555;
      bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 16'h0; bus.r1_wdata = 16'h0;

      // Requests during reset must not reach the memory.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", {bus.r0_gnt, bus.r1_gnt}, 0);
      chk("rst_mem_we", bus.mem_write_en, 0);
      chk("rst_mem_rd", bus.mem_read, 0);
      chk("rst_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      chk("rst_rdata", {bus.r0_rdata, bus.r1_rdata}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, starting from IDLE with r0 preferred.
      tbl[0] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 0};
      tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0};
      tbl[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 0};
      tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1};
      tbl[4] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0};
      tbl[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, -1};
      tbl[6] = '{1'b1, 1'b1, 16'h0041, 16'h1111, 1'b1, 1'b0, 16'h0040, 16'h0000, 1};
      tbl[7] = '{1'b1, 1'b1, 16'h0041, 16'h1111, 1'b0, 1'b0, 16'h0000, 16'h0000, 0};
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].q0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].q1, tbl[i].w1, tbl[i].a1, tbl[i].d1, g);
         chk($sformatf("tbl%0d_grant", i), 32'(g), 32'(tbl[i].exp_g));
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("raw_r0_rdata", bus.r0_rdata, 16'hBEEF);
      chk("r1_read_before_write", bus.r1_rdata, 16'h0000);
      chk("misaligned_write", tb_mem[8'h20], 16'h1111);

      // Continuous contention: r0 x MB, r1 x MB, repeating.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 16'h0010, 0, 1, 0, 16'h0020, 0, g);
         chk($sformatf("burst%0d", i), 32'(g), 32'((i / MB) % 2));
      end

      // Lone r1 streaming reads.
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 0, 16'(2 * i), 0, g);
         chk($sformatf("r1_stream%0d", i), 32'(g), 1);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, g);

      // Random traffic obeying the hold-until-grant handshake.
      pv[0] = 1'b0; pv[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin pw[k] = 1'b0; pa[k] = 16'h0; pd[k] = 16'h0; end
      for (int c = 0; c < 500; c++) begin
         for (int k = 0; k < 2; k++)
            if (!pv[k] && $urandom_range(99) < 60) begin
               pv[k] = 1'b1;
               pw[k] = 1'($urandom_range(1));
               pa[k] = 16'($urandom_range(31));
               pd[k] = 16'($urandom);
            end
         step(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1], g);
         if (g >= 0) pv[g] = 1'b0;
      end

      // Reset asserted partway through a granted write.
      @(negedge clk);
      bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 16'h0030; bus.r0_wdata = 16'hAAAA;
      bus.r1_req = 1'b0;
      #1;
      chk("pre_rst_we", bus.mem_write_en, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", bus.mem_write_en, 0);
      chk("mid_rst_gnt", bus.r0_gnt, 0);
      chk("mid_rst_addr", bus.mem_access_addr, 0);
      @(posedge clk);
      @(negedge clk);
      bus.r0_req = 1'b0;
      rst_n = 1'b1;
      model_reset();
      #1;
      chk("mem_unchanged", tb_mem[8'h18], ref_mem[8'h18]);
      chk("post_rst_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 0);
      chk("post_rst_rdata", {bus.r0_rdata, bus.r1_rdata}, 0);
      step(1, 0, 16'h0002, 0, 1, 0, 16'h0004, 0, g);
      chk("post_rst_rr", 32'(g), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, g);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
